// File: rtl/microwave_keypad_loader.sv
// Keypad entry, time validation and serial load/run/pause control for the cascaded countdown timer.
// Optional end-of-cook beep is built when MICROWAVE_BEEP_EN is defined.
module microwave_keypad_loader #(
  parameter int MAX_TENS    = 5,
  parameter int BEEP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        start,
  input  logic        stop,
  input  logic        finished,
  output logic        tmr_load,
  output logic [3:0]  tmr_in,
  output logic        tmr_enabled,
  output logic [15:0] entry_bcd,
  output logic [2:0]  entry_count,
  output logic        err,
  output logic        busy,
  output logic        done,
  output logic        beep
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [3:0] TENS_LIMIT = 4'(MAX_TENS);

`ifdef MICROWAVE_BEEP_EN
  localparam int             BEEP_W    = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES - 1);

  logic [BEEP_W-1:0] beep_cnt_reg;
`else
  // No beep hardware; BEEP_CYCLES has no effect in this build.
  assign beep = (BEEP_CYCLES < 0);
`endif

  state_t     state_reg;
  logic [1:0] load_idx_reg;

  logic digit_key;
  logic entry_full;
  logic entry_bad;
  logic any_event;

  assign digit_key  = key_valid && (key_code <= 4'd9);
  assign entry_full = (entry_count == 3'd4);
  assign entry_bad  = (entry_bcd[7:4] > TENS_LIMIT) || (entry_bcd[15:12] > TENS_LIMIT);
  assign any_event  = key_valid || start || stop;

  // Digits go out most-significant first so the first one ends up in minutes-tens.
  function automatic logic [3:0] load_digit(input logic [15:0] bcd, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = bcd[15:12];
      2'd1:    d = bcd[11:8];
      2'd2:    d = bcd[7:4];
      default: d = bcd[3:0];
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      load_idx_reg <= 2'd0;
      entry_bcd    <= 16'h0000;
      entry_count  <= 3'd0;
      tmr_load     <= 1'b0;
      tmr_in       <= 4'd0;
      tmr_enabled  <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef MICROWAVE_BEEP_EN
      beep         <= 1'b0;
      beep_cnt_reg <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && (entry_count != 3'd0)) begin
            if (entry_bad) begin
              err <= 1'b1;
            end else begin
              state_reg    <= LOAD;
              load_idx_reg <= 2'd1;
              tmr_load     <= 1'b1;
              tmr_in       <= load_digit(entry_bcd, 2'd0);
              busy         <= 1'b1;
            end
          end else if (stop) begin
            entry_bcd   <= 16'h0000;
            entry_count <= 3'd0;
          end else if (digit_key && !entry_full) begin
            entry_bcd   <= {entry_bcd[11:0], key_code};
            entry_count <= entry_count + 3'd1;
          end
        end

        LOAD: begin
          // load_idx_reg wraps to 0 after the last digit has been presented.
          if (load_idx_reg == 2'd0) begin
            state_reg   <= RUN;
            tmr_load    <= 1'b0;
            tmr_in      <= 4'd0;
            tmr_enabled <= 1'b1;
          end else begin
            tmr_in       <= load_digit(entry_bcd, load_idx_reg);
            load_idx_reg <= load_idx_reg + 2'd1;
          end
        end

        RUN: begin
          if (finished) begin
            state_reg   <= DONE;
            tmr_enabled <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
`ifdef MICROWAVE_BEEP_EN
            beep         <= 1'b1;
            beep_cnt_reg <= BEEP_LOAD;
`endif
          end else if (stop) begin
            state_reg   <= PAUSE;
            tmr_enabled <= 1'b0;
          end
        end

        PAUSE: begin
          if (stop) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            entry_bcd   <= 16'h0000;
            entry_count <= 3'd0;
          end else if (start) begin
            state_reg   <= RUN;
            tmr_enabled <= 1'b1;
          end
        end

        DONE: begin
          if (any_event) begin
            state_reg   <= IDLE;
            done        <= 1'b0;
            entry_bcd   <= 16'h0000;
            entry_count <= 3'd0;
`ifdef MICROWAVE_BEEP_EN
            beep         <= 1'b0;
            beep_cnt_reg <= '0;
          end else if (beep_cnt_reg != '0) begin
            beep_cnt_reg <= beep_cnt_reg - 1'b1;
          end else begin
            beep <= 1'b0;
`endif
          end
        end

        default: begin
          state_reg   <= IDLE;
          tmr_load    <= 1'b0;
          tmr_in      <= 4'd0;
          tmr_enabled <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_keypad_loader.sv
// Directed bench for microwave_keypad_loader with a queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_microwave_keypad_loader;

  localparam int TENS_MAX = 5;
  localparam int BEEP_LEN = 8;
`ifdef MICROWAVE_BEEP_EN
  localparam bit BEEP_ON = 1'b1;
`else
  localparam bit BEEP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        finished = 1'b0;
  logic        tmr_load;
  logic [3:0]  tmr_in;
  logic        tmr_enabled;
  logic [15:0] entry_bcd;
  logic [2:0]  entry_count;
  logic        err;
  logic        busy;
  logic        done;
  logic        beep;

  always #5 clk = ~clk;

  microwave_keypad_loader #(.MAX_TENS(TENS_MAX), .BEEP_CYCLES(BEEP_LEN)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .start(start), .stop(stop), .finished(finished),
    .tmr_load(tmr_load), .tmr_in(tmr_in), .tmr_enabled(tmr_enabled),
    .entry_bcd(entry_bcd), .entry_count(entry_count), .err(err),
    .busy(busy), .done(done), .beep(beep)
  );

  int vectors = 0;
  int miscompares = 0;
  int load_seq [4] = '{0, 1, 3, 0};

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the entry is a queue of digits, the phase a plain enum.
  typedef enum int {P_IDLE, P_LOAD, P_RUN, P_PAUSE, P_DONE} phase_t;
  phase_t m_phase = P_IDLE;
  int     m_q[$];
  int     m_pos = 0;
  int     m_age = 0;
  bit     m_err = 1'b0;

  function automatic logic [15:0] m_bcd();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return 16'(v);
  endfunction

  function automatic bit m_valid();
    int n  = m_q.size();
    int st = (n >= 2) ? m_q[n-2] : 0;
    int mt = (n == 4) ? m_q[0] : 0;
    return (st <= TENS_MAX) && (mt <= TENS_MAX);
  endfunction

  function automatic int m_load_digit();
    int pad = 4 - m_q.size();
    return (m_pos < pad) ? 0 : m_q[m_pos - pad];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE;
      m_q.delete();
      m_pos = 0;
      m_age = 0;
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      case (m_phase)
        P_IDLE: begin
          if (start && m_q.size() > 0) begin
            if (!m_valid()) m_err = 1'b1;
            else begin
              m_phase = P_LOAD;
              m_pos = 0;
            end
          end else if (stop) m_q.delete();
          else if (key_valid && key_code <= 4'd9 && m_q.size() < 4) m_q.push_back(int'(key_code));
        end
        P_LOAD: begin
          m_pos++;
          if (m_pos == 4) m_phase = P_RUN;
        end
        P_RUN: begin
          if (finished) begin
            m_phase = P_DONE;
            m_age = 0;
          end else if (stop) m_phase = P_PAUSE;
        end
        P_PAUSE: begin
          if (stop) begin
            m_phase = P_IDLE;
            m_q.delete();
          end else if (start) m_phase = P_RUN;
        end
        default: begin
          if (key_valid || start || stop) begin
            m_phase = P_IDLE;
            m_q.delete();
          end else m_age++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_tmr_load", tmr_load, m_phase == P_LOAD);
      check("m_tmr_in", tmr_in, (m_phase == P_LOAD) ? m_load_digit() : 0);
      check("m_tmr_enabled", tmr_enabled, m_phase == P_RUN);
      check("m_entry_bcd", entry_bcd, m_bcd());
      check("m_entry_count", entry_count, m_q.size());
      check("m_err", err, m_err);
      check("m_busy", busy, m_phase == P_LOAD || m_phase == P_RUN || m_phase == P_PAUSE);
      check("m_done", done, m_phase == P_DONE);
      check("m_beep", beep, BEEP_ON && m_phase == P_DONE && m_age < BEEP_LEN);
    end
  end

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
    $display("key %0d -> entry_bcd=%04h count=%0d", c, entry_bcd, entry_count);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("start -> load=%0b en=%0b err=%0b busy=%0b", tmr_load, tmr_enabled, err, busy);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    $display("stop -> en=%0b busy=%0b entry_bcd=%04h", tmr_enabled, busy, entry_bcd);
  endtask

  initial begin
    int beeps;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_entry", entry_bcd, 16'h0000);
    check("rst_outs", {tmr_load, tmr_in, tmr_enabled, err, busy, done, beep, entry_count}, 0);
    rst = 1'b0;

    // Entry and serial load of 01:30
    press(4'd1); press(4'd3); press(4'd0);
    check("t1_entry", entry_bcd, 16'h0130);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("t1_load", tmr_load, 1'b1);
      check("t1_in", tmr_in, load_seq[i]);
      check("t1_en_off", tmr_enabled, 1'b0);
      @(negedge clk);
      $display("load cycle %0d done", i);
    end
    check("t1_load_end", tmr_load, 1'b0);
    check("t1_run_en", tmr_enabled, 1'b1);
    check("t1_busy", busy, 1'b1);

    // Pause, resume without reload, cancel
    pulse_stop();
    check("t4_pause_en", tmr_enabled, 1'b0);
    check("t4_pause_busy", busy, 1'b1);
    pulse_start();
    check("t4_resume_en", tmr_enabled, 1'b1);
    check("t4_no_reload", tmr_load, 1'b0);
    @(negedge clk);
    pulse_stop();
    pulse_stop();
    check("t4_cancel_entry", entry_bcd, 16'h0000);
    check("t4_cancel_busy", busy, 1'b0);

    // Entry saturates at four digits, non-digit codes ignored
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("t2_entry", entry_bcd, 16'h1234);
    check("t2_count", entry_count, 3'd4);
    press(4'd11);
    check("t2_code11", entry_bcd, 16'h1234);
    pulse_stop();

    // Seconds-tens of 7 is rejected
    press(4'd1); press(4'd7); press(4'd0);
    pulse_start();
    check("t3_err", err, 1'b1);
    check("t3_entry", entry_bcd, 16'h0170);
    @(negedge clk);
    check("t3_err_pulse", err, 1'b0);
    check("t3_no_load", tmr_load, 1'b0);
    check("t3_idle", busy, 1'b0);

    // Minutes-tens of 6 is rejected, 59:59 accepted
    pulse_stop();
    press(4'd6); press(4'd0); press(4'd0); press(4'd0);
    pulse_start();
    check("t3_mtens_err", err, 1'b1);
    pulse_stop();
    press(4'd5); press(4'd9); press(4'd5); press(4'd9);
    pulse_start();
    check("t5_5959_err", err, 1'b0);
    check("t5_5959_load", tmr_load, 1'b1);
    check("t5_5959_first", tmr_in, 4'd5);
    repeat (4) @(negedge clk);
    check("t5_run", tmr_enabled, 1'b1);
    repeat (3) @(negedge clk);

    // finished beats a simultaneous stop
    finished = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    stop = 1'b0;
    $display("finished+stop -> done=%0b en=%0b", done, tmr_enabled);
    check("t5_done", done, 1'b1);
    check("t5_en_off", tmr_enabled, 1'b0);
    check("t5_busy", busy, 1'b0);
    beeps = int'(beep);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      beeps += int'(beep);
    end
    check("t5_beep_len", beeps, BEEP_ON ? 8 : 0);
    check("t5_done_hold", done, 1'b1);
    press(4'd5);
    check("t5_exit_done", done, 1'b0);
    check("t5_exit_count", entry_count, 3'd0);
    check("t5_exit_entry", entry_bcd, 16'h0000);

    // Asynchronous reset in the second load cycle
    press(4'd1); press(4'd3); press(4'd0);
    pulse_start();
    check("t6_load1", tmr_load, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("async reset -> load=%0b in=%0d busy=%0b", tmr_load, tmr_in, busy);
    check("t6_async_load", tmr_load, 1'b0);
    check("t6_async_in", tmr_in, 4'd0);
    check("t6_async_outs", {tmr_enabled, err, busy, done, beep, entry_count, entry_bcd}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle_count", entry_count, 3'd0);
    check("t6_idle_busy", busy, 1'b0);
    press(4'd4);
    check("t6_idle_key", entry_count, 3'd1);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/microwave_keypad_loader.md
Name: microwave_keypad_loader

Overview:
Front-end for the microwave countdown timer. Collects BCD digits from the keypad and checks that the entered time is valid. On start, it serially writes the four digits into the timer's cascaded load chain, then gates the timer's enable for run, pause and cancel. It observes the timer's finished flag to end the cook cycle, so it is the writer/controller for the timer's load/in/enabled/finished interface.

Parameters:
MAX_TENS, 5, largest digit accepted in the seconds-tens and minutes-tens positions.
BEEP_CYCLES, 8, length of the beep pulse in clocks; only used when BEEP_EN is defined.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
key_code  input  4  pressed key; 0-9 are digits, 10-15 are ignored.
start  input  1  one-cycle start/resume request.
stop  input  1  one-cycle pause/cancel request.
finished  input  1  timer reached 00:00.
tmr_load  output  1  drives the timer's load input.
tmr_in  output  4  drives the timer's serial digit input.
tmr_enabled  output  1  drives the timer's count enable.
entry_bcd  output  16  entered time {m_tens, m_unit, s_tens, s_unit}, for display.
entry_count  output  3  number of digits entered, 0-4.
err  output  1  one-cycle pulse when start is rejected as invalid.
busy  output  1  high in LOAD, RUN and PAUSE.
done  output  1  high in DONE.
beep  output  1  end-of-cook beep.

Behaviour:
- Reset (async): state=IDLE, entry_bcd=0, entry_count=0, all outputs 0.
- States: IDLE, LOAD, RUN, PAUSE, DONE. All outputs are registered.
- IDLE, digit entry:
  - key_valid with key_code<=9 and entry_count<4: entry_bcd <= {entry_bcd[11:0], key_code}; entry_count++.
  - Keys arriving at entry_count==4 are ignored.
  - Codes 10-15 are ignored.
- IDLE + start:
  - entry_count==0: start is ignored.
  - entry_bcd[7:4]>MAX_TENS or entry_bcd[15:12]>MAX_TENS: err=1 for one cycle, stay in IDLE, buffer kept.
  - Otherwise go to LOAD.
- IDLE + stop: clear entry_bcd and entry_count.
- LOAD: exactly 4 cycles.
  - tmr_load=1 and tmr_enabled=0 throughout.
  - tmr_in order: entry_bcd[15:12], [11:8], [7:4], [3:0]. The first digit written shifts through to minutes-tens.
  - Then go to RUN with tmr_load=0.
  - key_valid, start and stop are ignored during LOAD.
- RUN: tmr_enabled=1.
  - stop -> PAUSE.
  - finished -> DONE; finished has priority over a simultaneous stop.
  - Keys and start are ignored.
- PAUSE: tmr_enabled=0.
  - start -> RUN with no reload.
  - stop -> IDLE with entry cleared (cancel).
  - If start and stop arrive together, stop wins.
- DONE: done=1 and tmr_enabled=0.
  - Any key_valid, start or stop -> IDLE with entry cleared.
  - That key's digit is not captured.
- tmr_in=0 whenever tmr_load=0.
- err never asserts outside IDLE.

Optional Feature:
MICROWAVE_BEEP_EN
- Defined: on entry to DONE, beep=1 for exactly BEEP_CYCLES cycles, driven by a down-counter.
  - Leaving DONE early clears beep immediately.
  - Reset clears beep and the counter.
- Undefined: beep is tied to 0 and no counter is built.

Test Plan:
- Keys 1,3,0 then start -> entry_bcd=0x0130. tmr_load high for 4 cycles with tmr_in=0,1,3,0. Next cycle tmr_enabled=1, busy=1.
- Keys 1,2,3,4,5 -> entry_bcd=0x1234, entry_count=4. Key 11 -> no change.
- Keys 1,7,0 then start -> err one-cycle pulse, state stays IDLE, entry_bcd=0x0170, tmr_load never asserts.
- In RUN: stop -> tmr_enabled=0. start -> tmr_enabled=1 with no tmr_load. stop, stop -> IDLE with entry_bcd=0.
- In RUN: finished and stop in the same cycle -> DONE, done=1. With MICROWAVE_BEEP_EN, beep high for 8 cycles. Then key 5 -> IDLE, entry_count=0.
- rst asserted during the 2nd LOAD cycle -> tmr_load, tmr_in and all outputs go to 0 immediately, without waiting for a clock edge. After release the block is in IDLE with entry_count=0.
